// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared constants and FSM encoding for the serial subtractor
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit combinational full-subtractor cell
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first, one bit per clock
// Optional signed-overflow output ovf enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_ovf;
`endif

  logic w_d;
  logic w_bo;
  logic w_last;

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  full_subtractor u_fs (
    .x  (r_a[0]),
    .y  (r_b[0]),
    .bi (r_borrow),
    .d  (w_d),
    .bo (w_bo)
  );

  // Operands shift right so bit 0 always feeds the cell; results enter at the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_res    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_borrow <= w_bo;
          r_res    <= {w_d, r_res[WIDTH-1:1]};
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_diff  <= {w_d, r_res[WIDTH-1:1]};
            r_bout  <= w_bo;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor at WIDTH=8
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             ov;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  exp_t sb[$];
  exp_t last_exp;
  int   n_cmp;
  int   n_err;
  int   n_done;
  logic prev_done;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic bi);
    exp_t e;
    logic [WIDTH:0] full;
    full = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, bi};
    e.d  = full[WIDTH-1:0];
    e.bo = full[WIDTH];
    e.ov = (x[WIDTH-1] != y[WIDTH-1]) && (e.d[WIDTH-1] != x[WIDTH-1]);
    return e;
  endfunction

  task automatic push(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic bi);
    last_exp = model(x, y, bi);
    sb.push_back(last_exp);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      if (prev_done) check("done_width", 1, 0);
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("diff", {24'd0, diff}, {24'd0, e.d});
        check("bout", {31'd0, bout}, {31'd0, e.bo});
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", {31'd0, ovf}, {31'd0, e.ov});
`endif
      end
    end
    prev_done <= done;
  end

  // One operation with latency/busy measurement; repulse_at>0 re-asserts start in that SHIFT cycle.
  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic bi,
                        input int repulse_at);
    int lat;
    int bcnt;
    @(posedge clk); #1;
    start = 1'b1; a = x; b = y; bin = bi;
    push(x, y, bi);
    @(posedge clk); #1;
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
    lat = 0;
    bcnt = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (repulse_at > 0 && cyc == repulse_at) begin
        start = 1'b1; a = 8'hFF;
      end else if (repulse_at > 0 && cyc == repulse_at + 1) begin
        start = 1'b0;
      end
      if (busy) bcnt++;
      if (done && lat == 0) lat = cyc;
      if (!busy) break;
    end
    check("latency", lat, WIDTH + 1);
    check("busy_cycles", bcnt, WIDTH + 1);
  endtask

  initial begin
    int d0;
    int t1;
    int t2;
    n_cmp = 0; n_err = 0; n_done = 0; prev_done = 1'b0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_diff", {24'd0, diff}, 0);
    check("rst_bout", {31'd0, bout}, 0);
    rst = 1'b0;

    run_op(8'h05, 8'h03, 1'b0, 0);
    run_op(8'h03, 8'h05, 1'b0, 0);
    run_op(8'h00, 8'h00, 1'b1, 0);
    run_op(8'h80, 8'h01, 1'b0, 0);
    run_op(8'h10, 8'h01, 1'b0, 0);
    repeat (3) @(negedge clk);
    check("hold_diff", {24'd0, diff}, {24'd0, last_exp.d});
    check("hold_bout", {31'd0, bout}, {31'd0, last_exp.bo});

    d0 = n_done;
    run_op(8'h05, 8'h03, 1'b0, 3);
    repeat (3) @(negedge clk);
    check("repulse_one_done", n_done - d0, 1);

    @(posedge clk); #1;
    start = 1'b1; a = 8'h05; b = 8'h03; bin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_done", {31'd0, done}, 0);
    check("midrst_diff", {24'd0, diff}, 0);
    check("midrst_bout", {31'd0, bout}, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("midrst_ovf", {31'd0, ovf}, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    run_op(8'h0A, 8'h04, 1'b0, 0);

    @(posedge clk); #1;
    start = 1'b1; a = 8'h20; b = 8'h07; bin = 1'b0;
    push(8'h20, 8'h07, 1'b0);
    @(posedge clk); #1;
    a = 8'h07; b = 8'h20; bin = 1'b1;
    push(8'h07, 8'h20, 1'b1);
    t1 = 0; t2 = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (done) begin
        if (t1 == 0) t1 = cyc;
        else begin
          t2 = cyc; start = 1'b0; break;
        end
      end
    end
    start = 1'b0;
    check("b2b_gap", t2 - t1, WIDTH + 2);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 0);
    end
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
